instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch sequencer for the 16-bit processor. It sits between the instruction memory and the instruction register.
- It owns the program counter, drives the instruction-memory address, and waits out the memory's synchronous read latency.
- It then delivers the fetched word with a one-cycle register-load strobe, so the IR captures it on the following edge.
- The control FSM requests fetches and redirects the PC for jumps/branches.

Parameters:
- AW, 8, instruction-memory address width / PC width.
- RD_LAT, 1, synchronous read latency of instruction memory in clock edges. Legal range 1..7.
- RESET_PC, 0, PC value after reset (AW bits).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Fetch  input  1  fetch request from control FSM; sampled only when Busy=0.
- PC_Ld  input  1  load PC from PC_Din (jump/branch redirect).
- PC_Din  input  AW  new PC value.
- Instr_MEM  input  16  read data from instruction memory.
- Instr_Addr  output  AW  address to instruction memory (registered).
- Instr_IR  output  16  fetched instruction word to the IR data input (registered, held between fetches).
- IR_Ld  output  1  one-cycle load strobe to the IR.
- PC  output  AW  current program counter.
- Busy  output  1  fetch in progress; new Fetch ignored while high.

Behaviour:
- Reset (Rst_n=0 at a rising edge) sets: PC=RESET_PC, Instr_Addr=0, Instr_IR=0, IR_Ld=0, Busy=0, state=IDLE, latency counter=0. Reset overrides all other inputs.
- States:
  - IDLE → WAIT on Fetch=1.
  - WAIT → LOAD when counter reaches 0.
  - LOAD → IDLE unconditionally.
- IDLE, edge E0 with Fetch=1:
  - Instr_Addr<=PC, or <=PC_Din if PC_Ld=1 in the same cycle (redirect-and-fetch).
  - counter<=RD_LAT-1; Busy<=1; state<=WAIT.
- WAIT: each edge decrements the counter. At the edge where counter=0:
  - Instr_IR<=Instr_MEM.
  - IR_Ld<=1.
  - PC<=Instr_Addr+1, mod 2^AW; wraps 2^AW-1 → 0.
  - state<=LOAD.
- The word is therefore sampled at edge E_RD_LAT, i.e. exactly RD_LAT edges after the address was registered.
- LOAD (one cycle):
  - IR_Ld=1 during this cycle; the IR captures Instr_IR at the closing edge.
  - At that edge: IR_Ld<=0, Busy<=0, state<=IDLE.
- Fetch latency: request edge to IR_Ld high is RD_LAT+1 edges. Back-to-back throughput is one instruction per RD_LAT+2 cycles.
- Fetch while Busy=1: ignored, not queued. The FSM must hold or re-issue it after Busy falls.
- PC_Ld in IDLE without Fetch: PC<=PC_Din at that edge; no memory access.
- PC_Ld while Busy=1:
  - PC<=PC_Din immediately.
  - The post-fetch increment at the LOAD transition is suppressed. If PC_Ld coincides with that edge, PC_Din wins.
  - The in-flight fetch still completes from the old Instr_Addr.
- Instr_Addr changes only on an accepted fetch; stable through WAIT and LOAD.
- Instr_IR changes only at the WAIT→LOAD edge.
- Reset mid-fetch (WAIT or LOAD): fetch aborted, IR_Ld forced 0, no increment. Outputs take reset values.

Test Plan:
- Reset/basic fetch (RD_LAT=1, RESET_PC=0, mem[0]=16'h1234): Rst_n low 2 cycles, then Fetch pulse.
  - Instr_Addr=0 after E0.
  - Instr_IR=16'h1234 and IR_Ld=1 after E1, low after E2.
  - PC=1; Busy high E0..E2.
- Latency sweep RD_LAT=3, mem[5]=16'hABCD, PC preloaded to 5:
  - IR_Ld rises exactly 4 edges after the Fetch edge, with Instr_IR=16'hABCD; PC=6.
- Redirect-and-fetch: Fetch and PC_Ld with PC_Din=8'h40 in same IDLE cycle.
  - Instr_Addr=8'h40; fetched word = mem[0x40]; PC=8'h41.
- Fetch ignored while busy and PC_Ld mid-fetch:
  - Hold Fetch high continuously: fetches spaced RD_LAT+2 cycles with addresses 0,1,2.
  - PC_Ld=8'h10 during WAIT: current word still mem[old], PC stays 8'h10 (no increment), next fetch reads 0x10.
- Wrap and reset abort:
  - PC=8'hFF, fetch → PC=8'h00.
  - Start a fetch with RD_LAT=3 and drop Rst_n during WAIT: IR_Ld never pulses; PC=RESET_PC, Instr_IR=0, Busy=0 after the reset edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the program counter, drives the
// instruction-memory address, waits out the memory read latency and hands
// the fetched word to the IR with a one-cycle load strobe.
//
// Handshake: the control FSM raises Fetch. It is accepted only on an edge
// where Busy=0. Busy stays high from the accepting edge until the edge that
// closes the IR_Ld cycle. A Fetch seen while Busy=1 is dropped, not queued,
// so the requester holds or re-issues it after Busy falls.
module instr_fetch #(
    parameter int              AW       = 8,
    parameter int              RD_LAT   = 1,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Fetch,
    input  logic          PC_Ld,
    input  logic [AW-1:0] PC_Din,
    input  logic [15:0]   Instr_MEM,
    output logic [AW-1:0] Instr_Addr,
    output logic [15:0]   Instr_IR,
    output logic          IR_Ld,
    output logic [AW-1:0] PC,
    output logic          Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Counter starts at RD_LAT-1 so the word is captured exactly RD_LAT
    // edges after the address register is loaded.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    lat_cnt;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   ir_q;
    logic          ir_ld_q;
    logic          busy_q;
    // Set when the PC was redirected during WAIT; the redirect target must
    // survive the post-fetch increment.
    logic          redirected;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Fetch) state_nxt = ST_WAIT;
            ST_WAIT: if (lat_cnt == 3'd0) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: PC, address register, latency counter, IR word and strobes.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            ir_q       <= '0;
            ir_ld_q    <= 1'b0;
            busy_q     <= 1'b0;
            lat_cnt    <= 3'd0;
            redirected <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PC_Ld) pc_q <= PC_Din;
                    if (Fetch) begin
                        // Redirect-and-fetch reads from the new target.
                        addr_q     <= PC_Ld ? PC_Din : pc_q;
                        lat_cnt    <= LAT_INIT;
                        busy_q     <= 1'b1;
                        redirected <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (PC_Ld) begin
                        pc_q       <= PC_Din;
                        redirected <= 1'b1;
                    end
                    if (lat_cnt == 3'd0) begin
                        ir_q    <= Instr_MEM;
                        ir_ld_q <= 1'b1;
                        // A redirect, earlier or on this edge, wins over
                        // the sequential increment.
                        if (!PC_Ld && !redirected) pc_q <= addr_q + AW'(1);
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_LOAD: begin
                    if (PC_Ld) pc_q <= PC_Din;
                    ir_ld_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    ir_ld_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Instr_Addr = addr_q;
    assign Instr_IR   = ir_q;
    assign IR_Ld      = ir_ld_q;
    assign PC         = pc_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance with RD_LAT=1/RESET_PC=0 and
// one with RD_LAT=3/RESET_PC=8'h80, each fed by its own memory model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        f1, l1, f3, l3;
    logic [7:0]  din1, din3;
    logic [15:0] mem_data1, mem_data3;
    logic [7:0]  addr1, addr3, pc1, pc3;
    logic [15:0] ir1, ir3;
    logic        ld1, ld3, busy1, busy3;

    logic [15:0] mem [256];
    logic [15:0] p3_0, p3_1;

    int checks = 0;
    int errors = 0;

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_fetch #(.AW(8), .RD_LAT(1), .RESET_PC(8'h00)) u_d1 (
        .Clk(clk), .Rst_n(rst_n), .Fetch(f1), .PC_Ld(l1), .PC_Din(din1),
        .Instr_MEM(mem_data1), .Instr_Addr(addr1), .Instr_IR(ir1),
        .IR_Ld(ld1), .PC(pc1), .Busy(busy1)
    );

    instr_fetch #(.AW(8), .RD_LAT(3), .RESET_PC(8'h80)) u_d3 (
        .Clk(clk), .Rst_n(rst_n), .Fetch(f3), .PC_Ld(l3), .PC_Din(din3),
        .Instr_MEM(mem_data3), .Instr_Addr(addr3), .Instr_IR(ir3),
        .IR_Ld(ld3), .PC(pc3), .Busy(busy3)
    );

    // Memory with one-edge latency: data valid before the next edge.
    assign mem_data1 = mem[addr1];

    // Memory with three-edge latency: two pipeline stages behind the address.
    always @(posedge clk) begin
        p3_0 <= mem[addr3];
        p3_1 <= p3_0;
    end
    assign mem_data3 = p3_1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f1 = 0; l1 = 0; din1 = 0; f3 = 0; l3 = 0; din3 = 0;
        tick(); tick();
        checks++; if (pc1 !== 8'h00) begin errors++; $display("FAIL reset_pc1: got %h exp 00", pc1); end
        checks++; if (addr1 !== 8'h00) begin errors++; $display("FAIL reset_addr1: got %h exp 00", addr1); end
        checks++; if (ir1 !== 16'h0) begin errors++; $display("FAIL reset_ir1: got %h exp 0000", ir1); end
        checks++; if (ld1 !== 1'b0) begin errors++; $display("FAIL reset_ld1: got %b exp 0", ld1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b exp 0", busy1); end
        checks++; if (pc3 !== 8'h80) begin errors++; $display("FAIL reset_pc3: got %h exp 80", pc3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b exp 0", busy3); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fetch();
        f1 = 1; tick(); f1 = 0;
        checks++; if (addr1 !== 8'h00) begin errors++; $display("FAIL basic_addr: got %h exp 00", addr1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b exp 1", busy1); end
        checks++; if (ld1 !== 1'b0) begin errors++; $display("FAIL basic_ld_e0: got %b exp 0", ld1); end
        tick();
        checks++; if (ir1 !== 16'h1234) begin errors++; $display("FAIL basic_ir: got %h exp 1234", ir1); end
        checks++; if (ld1 !== 1'b1) begin errors++; $display("FAIL basic_ld_e1: got %b exp 1", ld1); end
        checks++; if (pc1 !== 8'h01) begin errors++; $display("FAIL basic_pc: got %h exp 01", pc1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy_e1: got %b exp 1", busy1); end
        tick();
        checks++; if (ld1 !== 1'b0) begin errors++; $display("FAIL basic_ld_e2: got %b exp 0", ld1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_e2: got %b exp 0", busy1); end
        checks++; if (ir1 !== 16'h1234) begin errors++; $display("FAIL basic_ir_hold: got %h exp 1234", ir1); end
    endtask

    task automatic test_latency();
        l3 = 1; din3 = 8'h05; tick(); l3 = 0;
        checks++; if (pc3 !== 8'h05) begin errors++; $display("FAIL lat_preload_pc: got %h exp 05", pc3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat_preload_busy: got %b exp 0", busy3); end
        checks++; if (addr3 !== 8'h00) begin errors++; $display("FAIL lat_preload_addr: got %h exp 00", addr3); end
        f3 = 1; tick(); f3 = 0;
        checks++; if (addr3 !== 8'h05) begin errors++; $display("FAIL lat_addr: got %h exp 05", addr3); end
        checks++; if (ld3 !== 1'b0) begin errors++; $display("FAIL lat_ld_edge1: got %b exp 0", ld3); end
        for (int n = 2; n <= 4; n++) begin
            tick();
            checks++;
            if (ld3 !== (n == 4)) begin
                errors++; $display("FAIL lat_ld_edge%0d: got %b exp %b", n, ld3, (n == 4));
            end
        end
        checks++; if (ir3 !== 16'hABCD) begin errors++; $display("FAIL lat_ir: got %h exp abcd", ir3); end
        checks++; if (pc3 !== 8'h06) begin errors++; $display("FAIL lat_pc: got %h exp 06", pc3); end
        tick();
        checks++; if (ld3 !== 1'b0) begin errors++; $display("FAIL lat_ld_after: got %b exp 0", ld3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat_busy_after: got %b exp 0", busy3); end
    endtask

    task automatic test_redirect();
        f1 = 1; l1 = 1; din1 = 8'h40; tick(); f1 = 0; l1 = 0;
        checks++; if (addr1 !== 8'h40) begin errors++; $display("FAIL redir_addr: got %h exp 40", addr1); end
        tick();
        checks++; if (ir1 !== 16'h4040) begin errors++; $display("FAIL redir_ir: got %h exp 4040", ir1); end
        checks++; if (ld1 !== 1'b1) begin errors++; $display("FAIL redir_ld: got %b exp 1", ld1); end
        checks++; if (pc1 !== 8'h41) begin errors++; $display("FAIL redir_pc: got %h exp 41", pc1); end
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL redir_busy: got %b exp 0", busy1); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h1234; exp_w[1] = 16'h1111; exp_w[2] = 16'h2222;
        l1 = 1; din1 = 8'h00; tick(); l1 = 0;
        f1 = 1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            checks++;
            if (ld1 !== (t % 3 == 2)) begin
                errors++; $display("FAIL b2b_ld_t%0d: got %b exp %b", t, ld1, (t % 3 == 2));
            end
            checks++;
            if (busy1 !== (t % 3 != 0)) begin
                errors++; $display("FAIL b2b_busy_t%0d: got %b exp %b", t, busy1, (t % 3 != 0));
            end
            if (t % 3 == 1) begin
                checks++;
                if (addr1 !== 8'((t - 1) / 3)) begin
                    errors++; $display("FAIL b2b_addr_t%0d: got %h exp %h", t, addr1, 8'((t - 1) / 3));
                end
            end
            if (t % 3 == 2) begin
                checks++;
                if (ir1 !== exp_w[(t - 2) / 3]) begin
                    errors++; $display("FAIL b2b_ir_t%0d: got %h exp %h", t, ir1, exp_w[(t - 2) / 3]);
                end
            end
        end
        f1 = 0;
        checks++; if (pc1 !== 8'h03) begin errors++; $display("FAIL b2b_pc: got %h exp 03", pc1); end
    endtask

    task automatic test_pc_ld_mid_fetch();
        f3 = 1; tick(); f3 = 0;
        checks++; if (addr3 !== 8'h06) begin errors++; $display("FAIL midld_addr: got %h exp 06", addr3); end
        tick();
        l3 = 1; din3 = 8'h10; tick(); l3 = 0;
        checks++; if (pc3 !== 8'h10) begin errors++; $display("FAIL midld_pc_now: got %h exp 10", pc3); end
        checks++; if (ld3 !== 1'b0) begin errors++; $display("FAIL midld_ld_early: got %b exp 0", ld3); end
        tick();
        checks++; if (ld3 !== 1'b1) begin errors++; $display("FAIL midld_ld: got %b exp 1", ld3); end
        checks++; if (ir3 !== 16'h6666) begin errors++; $display("FAIL midld_ir_old: got %h exp 6666", ir3); end
        checks++; if (pc3 !== 8'h10) begin errors++; $display("FAIL midld_no_inc: got %h exp 10", pc3); end
        tick();
        checks++; if (pc3 !== 8'h10) begin errors++; $display("FAIL midld_pc_idle: got %h exp 10", pc3); end
        f3 = 1; tick(); f3 = 0;
        checks++; if (addr3 !== 8'h10) begin errors++; $display("FAIL midld_next_addr: got %h exp 10", addr3); end
        tick(); tick(); tick();
        checks++; if (ir3 !== 16'h1010) begin errors++; $display("FAIL midld_next_ir: got %h exp 1010", ir3); end
        checks++; if (pc3 !== 8'h11) begin errors++; $display("FAIL midld_next_pc: got %h exp 11", pc3); end
        tick();
    endtask

    task automatic test_pc_ld_at_load_edge();
        f1 = 1; tick(); f1 = 0;
        l1 = 1; din1 = 8'h33; tick(); l1 = 0;
        checks++; if (ld1 !== 1'b1) begin errors++; $display("FAIL edgeld_ld: got %b exp 1", ld1); end
        checks++; if (ir1 !== 16'h3333) begin errors++; $display("FAIL edgeld_ir: got %h exp 3333", ir1); end
        checks++; if (pc1 !== 8'h33) begin errors++; $display("FAIL edgeld_pc: got %h exp 33", pc1); end
        tick();
    endtask

    task automatic test_wrap();
        l1 = 1; din1 = 8'hFF; tick(); l1 = 0;
        f1 = 1; tick(); f1 = 0;
        checks++; if (addr1 !== 8'hFF) begin errors++; $display("FAIL wrap_addr: got %h exp ff", addr1); end
        tick();
        checks++; if (ir1 !== 16'hFFEE) begin errors++; $display("FAIL wrap_ir: got %h exp ffee", ir1); end
        checks++; if (pc1 !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h exp 00", pc1); end
        tick();
    endtask

    task automatic test_reset_abort();
        f3 = 1; tick(); f3 = 0;
        tick();
        rst_n = 1'b0; tick();
        checks++; if (ld3 !== 1'b0) begin errors++; $display("FAIL abort_ld: got %b exp 0", ld3); end
        checks++; if (pc3 !== 8'h80) begin errors++; $display("FAIL abort_pc: got %h exp 80", pc3); end
        checks++; if (ir3 !== 16'h0) begin errors++; $display("FAIL abort_ir: got %h exp 0000", ir3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy3); end
        checks++; if (addr3 !== 8'h00) begin errors++; $display("FAIL abort_addr: got %h exp 00", addr3); end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (ld3 !== 1'b0 || busy3 !== 1'b0) begin
                errors++; $display("FAIL abort_quiet_%0d: got ld=%b busy=%b exp 0/0", k, ld3, busy3);
            end
        end
    endtask

    // Main sequence.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h03] = 16'h3333;
        mem[8'h05] = 16'hABCD;
        mem[8'h06] = 16'h6666;
        mem[8'h10] = 16'h1010;
        mem[8'h40] = 16'h4040;
        mem[8'hFF] = 16'hFFEE;

        test_reset();
        test_basic_fetch();
        test_latency();
        test_redirect();
        test_back_to_back();
        test_pc_ld_mid_fetch();
        test_pc_ld_at_load_edge();
        test_wrap();
        test_reset_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
